ps2_key_sequencer: RTL and testbench

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

---
 rtl/ps2_key_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//   Turns the raw PS/2 set-2 byte stream from a receiver FIFO into key
//   events. It handles the E0 (extended) and F0 (break) prefixes and skips the
//   8-byte Pause sequence, reporting that sequence as a single event with code
//   0xE1. It also tracks the shift/ctrl/alt modifier state and raises a sticky
//   error on malformed bytes or on a stalled multi-byte sequence.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ps2_rdy    receiver has a byte at the head of its FIFO
//   ps2_data   head-of-FIFO byte
//   ps2_done   byte consumed this cycle (receiver pops on this edge)
//   key_valid  event pending, held until key_ack
//   key_code   scan code of the pending event
//   key_ext    event carried an E0 prefix
//   key_brk    event is a release (F0 prefix)
//   key_ack    consumer accepts the pending event
//   mods       {alt, ctrl, rshift, lshift}
//   err        sticky sequence / timeout error
//   err_clr    clears err (a same-cycle error wins)
module ps2_key_sequencer #(
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_rdy,
    input  logic [7:0] ps2_data,
    output logic       ps2_done,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    input  logic       key_ack,
    output logic [3:0] mods,
    output logic       err,
    input  logic       err_clr
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [7:0]      code_q, code_d;
    logic            ext_q, ext_d;
    logic            brk_q, brk_d;
    logic [3:0]      mods_q, mods_d;
    logic            err_q, err_d;

    logic            in_ext, in_brk, err_set, emit, status_byte;

    // Nothing is consumed while an event is pending, so an unacknowledged
    // event back-pressures the receiver FIFO.
    assign ps2_done = ps2_rdy & ~valid_q & ~rst;

    assign in_ext = (state_q == S_EXT) || (state_q == S_EXTBRK);
    assign in_brk = (state_q == S_BRK) || (state_q == S_EXTBRK);

    // Keyboard status/response bytes that are meaningless as key codes.
    assign status_byte = (ps2_data == 8'hAA) || (ps2_data == 8'hFA) ||
                         (ps2_data == 8'hEE) || (ps2_data == 8'hFE) ||
                         (ps2_data == 8'hFC);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        code_d  = code_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        mods_d  = mods_q;
        err_set = 1'b0;
        emit    = 1'b0;

        if (valid_q && key_ack)
            valid_d = 1'b0;

        if (ps2_done) begin
            cnt_d = '0;
            if (ps2_data == 8'h00 || ps2_data == 8'hFF) begin
                err_set = 1'b1;
                state_d = S_IDLE;
                skip_d  = '0;
            end else if (state_q == S_PAUSE) begin
                // Pause bytes are swallowed blindly; the last one reports it.
                if (skip_q == 3'd1) begin
                    valid_d = 1'b1;
                    code_d  = 8'hE1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    state_d = S_IDLE;
                    skip_d  = '0;
                end else begin
                    skip_d = skip_q - 3'd1;
                end
            end else begin
                unique case (ps2_data)
                    8'hE0: state_d = in_brk ? S_EXTBRK : S_EXT;
                    8'hF0: state_d = in_ext ? S_EXTBRK : S_BRK;
                    8'hE1: begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end
                    default: begin
                        state_d = S_IDLE;
                        if (state_q == S_IDLE && status_byte) begin
                            // dropped
                        end else if (in_ext && (ps2_data == 8'h12 || ps2_data == 8'h59)) begin
                            // fake shift injected around extended keys: dropped
                        end else begin
                            emit = 1'b1;
                        end
                    end
                endcase
            end
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (!valid_q) begin
            // Stalled mid-sequence: abandon the prefix and flag it.
            if (cnt_q == TO_LAST) begin
                err_set = 1'b1;
                state_d = S_IDLE;
                skip_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (emit) begin
            valid_d = 1'b1;
            code_d  = ps2_data;
            ext_d   = in_ext;
            brk_d   = in_brk;
            unique case (ps2_data)
                8'h12:   if (!in_ext) mods_d[0] = ~in_brk;
                8'h59:   if (!in_ext) mods_d[1] = ~in_brk;
                8'h14:   mods_d[2] = ~in_brk;
                8'h11:   mods_d[3] = ~in_brk;
                default: ;
            endcase
        end

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            mods_q  <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            mods_q  <= mods_d;
            err_q   <= err_d;
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_ext   = ext_q;
    assign key_brk   = brk_q;
    assign mods      = mods_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer
//   Directed scenarios with literal expectations, then a randomized byte
//   stream. A behavioural model (prefix flags, pause byte budget, stall
//   counter) predicts every output; one negedge process compares each cycle.
module tb_ps2_key_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst, ps2_rdy, ps2_done, key_valid, key_ext, key_brk;
    logic       key_ack, err, err_clr;
    logic [7:0] ps2_data, key_code;
    logic [3:0] mods;

    always #5 clk = ~clk;

    ps2_key_sequencer #(.IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ps2_rdy(ps2_rdy), .ps2_data(ps2_data),
        .ps2_done(ps2_done), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_brk(key_brk), .key_ack(key_ack),
        .mods(mods), .err(err), .err_clr(err_clr)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    bit         m_valid, m_ext, m_brk, m_err;
    logic [7:0] m_code;
    logic [3:0] m_mods;
    bit         p_ext, p_brk;     // prefixes seen so far
    int         p_skip;           // pause bytes still to swallow
    int         stall;            // cycles spent waiting mid-sequence

    task automatic m_emit(input logic [7:0] b);
        m_valid = 1'b1;
        m_code  = b;
        m_ext   = p_ext;
        m_brk   = p_brk;
        if (b == 8'h12 && !p_ext) m_mods[0] = !p_brk;
        if (b == 8'h59 && !p_ext) m_mods[1] = !p_brk;
        if (b == 8'h14)           m_mods[2] = !p_brk;
        if (b == 8'h11)           m_mods[3] = !p_brk;
    endtask

    task automatic model_step(output bit consumed);
        bit fault;
        logic [7:0] b;
        consumed = 1'b0;
        fault = 1'b0;
        b = ps2_data;
        if (rst) begin
            m_valid = 0; m_ext = 0; m_brk = 0; m_err = 0;
            m_code = 8'h00; m_mods = 4'h0;
            p_ext = 0; p_brk = 0; p_skip = 0; stall = 0;
        end else begin
            consumed = ps2_rdy && !m_valid;
            if (m_valid && key_ack) m_valid = 1'b0;
            if (consumed) begin
                stall = 0;
                if (b == 8'h00 || b == 8'hFF) begin
                    fault = 1; p_ext = 0; p_brk = 0; p_skip = 0;
                end else if (p_skip > 0) begin
                    p_skip--;
                    if (p_skip == 0) m_emit(8'hE1);
                end else if (b == 8'hE0) begin
                    p_ext = 1;
                end else if (b == 8'hF0) begin
                    p_brk = 1;
                end else if (b == 8'hE1) begin
                    p_ext = 0; p_brk = 0; p_skip = 7;
                end else if (!p_ext && !p_brk && (b == 8'hAA || b == 8'hFA ||
                             b == 8'hEE || b == 8'hFE || b == 8'hFC)) begin
                    // status byte, ignored
                end else if (p_ext && (b == 8'h12 || b == 8'h59)) begin
                    p_ext = 0; p_brk = 0;
                end else begin
                    m_emit(b);
                    p_ext = 0; p_brk = 0;
                end
            end else if (p_ext || p_brk || p_skip > 0) begin
                if (stall == TO - 1) begin
                    fault = 1; p_ext = 0; p_brk = 0; p_skip = 0; stall = 0;
                end else begin
                    stall++;
                end
            end else begin
                stall = 0;
            end
            if (err_clr) m_err = 0;
            if (fault)   m_err = 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ps2_done",  8'(ps2_done),  8'(ps2_rdy && !m_valid && !rst));
            cmp("key_valid", 8'(key_valid), 8'(m_valid));
            cmp("key_code",  key_code,      m_code);
            cmp("key_ext",   8'(key_ext),   8'(m_ext));
            cmp("key_brk",   8'(key_brk),   8'(m_brk));
            cmp("mods",      8'(mods),      8'(m_mods));
            cmp("err",       8'(err),       8'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit rdy, input logic [7:0] d,
                       input bit ack, input bit clr, output bit consumed);
        rst = r; ps2_rdy = rdy; ps2_data = d; key_ack = ack; err_clr = clr;
        @(posedge clk);
        model_step(consumed);
        #1;
    endtask

    task automatic byte_in(input logic [7:0] d);
        bit c;
        cyc(0, 1, d, 0, 0, c);
        if (!c) cmp("byte_taken", 8'(c), 8'h01);
    endtask

    task automatic idle(input int n, input bit ack);
        bit c;
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, ack, 0, c);
    endtask

    logic [7:0] q[$];

    function automatic logic [7:0] rb();
        return 8'($urandom_range(1, 254));
    endfunction

    task automatic gen_seq();
        logic [7:0] modk[4] = '{8'h12, 8'h59, 8'h14, 8'h11};
        logic [7:0] stat[7] = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC};
        case ($urandom_range(0, 9))
            0, 1, 2, 3: q.push_back(rb());
            4: begin q.push_back(8'hE0); q.push_back(rb()); end
            5: begin q.push_back(8'hF0); q.push_back(rb()); end
            6: begin q.push_back(8'hE0); q.push_back(8'hF0); q.push_back(rb()); end
            7: begin
                q.push_back(8'hE1);
                for (int i = 0; i < 7; i++) q.push_back(rb());
            end
            8: begin
                if ($urandom_range(0, 1) == 1) q.push_back(8'hE0);
                if ($urandom_range(0, 1) == 1) q.push_back(8'hF0);
                q.push_back(modk[$urandom_range(0, 3)]);
            end
            default: begin
                if ($urandom_range(0, 2) == 0) q.push_back(8'hE0);
                q.push_back(stat[$urandom_range(0, 6)]);
            end
        endcase
    endtask

    initial begin
        bit c;
        int gap;
        bit rdy;
        rst = 1; ps2_rdy = 0; ps2_data = 8'h00; key_ack = 0; err_clr = 0;
        cyc(1, 1, 8'h1C, 1, 0, c);
        chk_en = 1'b1;
        cyc(1, 1, 8'h1C, 0, 1, c);
        cmp("rst_done",  8'(ps2_done), 8'h00);
        cmp("rst_valid", 8'(key_valid), 8'h00);
        cmp("rst_mods",  8'(mods), 8'h00);
        cmp("rst_code",  key_code, 8'h00);

        // single make code
        byte_in(8'h1C);
        cmp("s1_valid", 8'(key_valid), 8'h01);
        cmp("s1_code",  key_code, 8'h1C);
        cmp("s1_extbrk", {6'b0, key_ext, key_brk}, 8'h00);
        idle(1, 1);
        cmp("s1_ack", 8'(key_valid), 8'h00);

        // extended release, back-to-back bytes
        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h75);
        cmp("s2_code", key_code, 8'h75);
        cmp("s2_extbrk", {6'b0, key_ext, key_brk}, 8'h03);
        idle(1, 1);

        // shift make/break and fake shift
        byte_in(8'h12);
        cmp("s3_mods_make", 8'(mods), 8'h01);
        idle(1, 1);
        byte_in(8'hF0); byte_in(8'h12);
        cmp("s3_mods_brk", 8'(mods), 8'h00);
        idle(1, 1);
        byte_in(8'hE0); byte_in(8'h12);
        cmp("s3_fake_valid", 8'(key_valid), 8'h00);
        cmp("s3_fake_mods",  8'(mods), 8'h00);

        // pause sequence
        byte_in(8'hE1); byte_in(8'h14); byte_in(8'h77); byte_in(8'hE1);
        byte_in(8'hF0); byte_in(8'h14); byte_in(8'hF0);
        cmp("s4_mid_valid", 8'(key_valid), 8'h00);
        byte_in(8'h77);
        cmp("s4_code", key_code, 8'hE1);
        cmp("s4_extbrk_mods", {key_ext, key_brk, 2'b0, mods}, 8'h00);
        idle(1, 1);

        // stalled prefix
        byte_in(8'hE0);
        idle(TO - 1, 0);
        cmp("s5_err_early", 8'(err), 8'h00);
        idle(1, 0);
        cmp("s5_err", 8'(err), 8'h01);
        byte_in(8'h1C);
        cmp("s5_ext", 8'(key_ext), 8'h00);
        cyc(0, 0, 8'h00, 1, 1, c);
        cmp("s5_clr", 8'(err), 8'h00);

        // back-pressure
        byte_in(8'h1C);
        cyc(0, 1, 8'h32, 0, 0, c);
        cmp("s6_hold_done", 8'(ps2_done), 8'h00);
        cmp("s6_hold_code", key_code, 8'h1C);
        cyc(0, 1, 8'h32, 1, 0, c);
        cmp("s6_ack_valid", 8'(key_valid), 8'h00);
        byte_in(8'h32);
        cmp("s6_next_code", key_code, 8'h32);
        idle(1, 1);
        byte_in(8'h00);
        cmp("s6_zero_err", 8'(err), 8'h01);
        cmp("s6_zero_valid", 8'(key_valid), 8'h00);

        // randomized stream
        gap = 0;
        for (int i = 0; i < 5000; i++) begin
            if (q.size() == 0) gen_seq();
            rdy = (gap == 0) && ($urandom_range(0, 9) < 7);
            if (gap > 0) gap--;
            else if ($urandom_range(0, 99) < 2) gap = $urandom_range(10, 25);
            cyc($urandom_range(0, 299) == 0, rdy, q[0],
                $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, c);
            if (c) void'(q.pop_front());
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
